rom_arbiter: RTL
================

# rom_arbiter

Two-port, round-robin arbiter that shares the single synchronous game-sequence ROM between two requesters: the sequence flasher on port 0 and the answer checker on port 1. It serializes read requests and drives the ROM address. It tracks the fixed ROM read latency and returns each data word, with a one-cycle valid strobe, only to the requester that issued the read. It sits between the game-control FSMs and the ROM macro.

## Interface
- AW, 5, address width (ROM depth 32).
- DW, 5, data width of ROM output.
- RD_LAT, 2, ROM read latency in clock edges, counted from the edge that registers the address to the edge that samples q. Legal range is 2..7.
- clock  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0  in  1  port 0 read request; level, held until gnt0 is seen.
- addr0  in  AW  port 0 read address; stable while req0 is high.
- gnt0  out  1  one-cycle pulse; port 0 request accepted.
- rvalid0  out  1  one-cycle pulse; rdata0 holds port 0 read data.
- rdata0  out  DW  port 0 read data; holds its value until the next port 0 rvalid.
- req1, addr1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- address  out  AW  registered ROM address.
- q  in  DW  ROM read data.
- busy  out  1  high while a read is outstanding.

## Operation
- Reset (rst=1 at an edge) clears all state:
  - address=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0.
  - State goes to IDLE, latency counter=0, owner tag=0.
  - last_gnt=1, so port 0 wins the first tie.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding; a 3-bit latency counter counts up to RD_LAT.
- Issue, taken at an edge in IDLE, or at the completing edge of WAIT, with at least one req sampled high:
  - Pick the winner.
  - Register address<=addr_winner and owner<=winner.
  - Pulse gnt_winner=1 for one cycle. Set busy=1 and counter=1. Go to (or stay in) WAIT.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: the port other than last_gnt wins.
  - last_gnt updates to the winner on every issue.
- WAIT: the counter increments each edge.
- Completion, at the edge where counter==RD_LAT:
  - Capture rdata_owner<=q and pulse rvalid_owner=1 for one cycle.
  - The other port's rdata and rvalid are untouched.
  - In the same edge, a new issue may occur if any req is sampled high. Otherwise go to IDLE with busy=0.
- Requesters drop req at the edge after seeing gnt. RD_LAT>=2 guarantees that the stale req is not re-sampled, so there is no double grant. A req still high at the next issue point is treated as a new read.
- At most one read is outstanding at any time. gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
- address holds its last value when no read is outstanding.
- Requests arriving during WAIT wait for the next issue point; none is dropped.
- Reset in WAIT aborts the read: no rvalid is produced, and the next grant goes to port 0 on a tie.

## Timing
- Grant latency from IDLE: req sampled high at edge E, so gnt and address are updated at E, visible in cycle E..E+1.
- Data latency: rvalid is visible RD_LAT cycles after gnt, i.e. updated at edge E+RD_LAT.
- Throughput: one read per RD_LAT cycles under continuous requests. With RD_LAT=2 and both ports busy, the grants alternate 0,1,0,1 every 2 cycles.
- Worst-case wait for a port with its request held is 2*RD_LAT cycles.
- No combinational path from any input to any output.

## Test plan
- Reset values:
  - Assert rst for 3 cycles with req0=req1=1.
  - Required: all outputs 0 and busy=0 throughout. The first grant after rst falls goes to port 0.
- Single read:
  - ROM[5]=5'h0A; req0=1, addr0=5 until gnt0.
  - Required: address=5 in the gnt0 cycle; rvalid0 two cycles later with rdata0=5'h0A; rvalid1 and gnt1 never high.
- Simultaneous requests:
  - req0=1 with addr0=3 (ROM[3]=5'h03); req1=1 with addr1=9 (ROM[9]=5'h11); both assert in the same cycle after reset.
  - Required: gnt0 first, then gnt1 two cycles later, in the cycle of rvalid0=1 with rdata0=5'h03. rvalid1 follows two cycles after gnt1, with rdata1=5'h11.
- Continuous contention:
  - Hold req0 and req1 high for 20 cycles; RD_LAT=2.
  - Required: grants alternate, 10 total, 5 per port. No two gnt pulses within 2 cycles of each other. Each rvalid routes to the port of the matching gnt.
- Reset mid-read:
  - Assert rst at the edge after gnt1.
  - Required: no rvalid1; busy=0 next cycle; rdata1=0.
- Latency parameter sweep:
  - Repeat the single-read test with RD_LAT=2, 3 and 7.
  - Required: rvalid exactly RD_LAT cycles after gnt; busy high for exactly RD_LAT cycles.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter in front of the synchronous
// game-sequence ROM. Port 0 is the sequence flasher and port 1 is the answer
// checker. Only one read can be outstanding at a time. Each read waits the
// fixed ROM latency, and its data word goes back only to the port that issued it.
module rom_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 5,
  parameter int RD_LAT = 2   // edges from address register to q sample, 2..7
) (
  input  logic          clock_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic [AW-1:0] addr0_i,
  output logic          gnt0_o,
  output logic          rvalid0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic [AW-1:0] addr1_i,
  output logic          gnt1_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata1_o,
  output logic [AW-1:0] address_o,
  input  logic [DW-1:0] q_i,
  output logic          busy_o
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_gnt_q, last_gnt_d;
  logic [AW-1:0] address_q, address_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          busy_q, busy_d;

  logic          complete_s;
  logic          issue_s;
  logic          winner_s;

  // Decode completion, issue point and the round-robin winner
  always_comb begin
    complete_s = (state_q == S_WAIT) && (cnt_q == LAT);
    issue_s    = ((state_q == S_IDLE) || complete_s) && (req0_i || req1_i);
    if (req0_i && req1_i) begin
      winner_s = ~last_gnt_q;          // tie: the port not served last time
    end else if (req1_i) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state logic: latency count, data return, then (possibly) a new issue
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    address_d  = address_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = 3'd0;
        busy_d = 1'b0;
      end
      S_WAIT: begin
        if (complete_s) begin
          if (owner_q) begin
            rdata1_d  = q_i;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = q_i;
            rvalid0_d = 1'b1;
          end
          // Fall back to idle unless a new read is issued on this same edge
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase

    if (issue_s) begin
      address_d  = winner_s ? addr1_i : addr0_i;
      owner_d    = winner_s;
      last_gnt_d = winner_s;
      gnt0_d     = ~winner_s;
      gnt1_d     = winner_s;
      busy_d     = 1'b1;
      cnt_d      = 3'd1;
      state_d    = S_WAIT;
    end else begin
      owner_d = owner_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;   // port 0 wins the first tie
      address_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      address_q  <= address_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign address_o = address_q;
  assign busy_o    = busy_q;

endmodule
